seq_pattern_tx: RTL and testbench

Serial pattern transmitter: the transmit-side companion to the team's serial sequence detectors. It accepts a PAT_W-bit pattern word over a valid/ready handshake and shifts it out MSB-first on a single serial line, one bit per clock. The word repeats a programmable number of times, with a fixed idle gap between repetitions. It drives detector benches and on-chip loopback paths.

---
 rtl/seq_tx_pkg.sv | 15 +
 rtl/seq_shift_reg.sv | 37 +++
 rtl/seq_pattern_tx.sv | 162 ++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_tx_pkg;

    localparam int PAT_W_DEF = 5;
    localparam int GAP_DEF   = 2;
    localparam int REP_W     = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2,
        S_GAP   = 2'd3
    } state_e;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, MSB-first shift register; zeros enter at the LSB on each shift.
module seq_shift_reg
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             msb
);

    logic [PAT_W-1:0] sr_q;
    logic [PAT_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {sr_q[PAT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: repeats a latched word MSB-first with idle gaps.
// Optional even-parity bit per frame is enabled by defining SEQ_TX_PARITY_EN.
module seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int GAP   = GAP_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [REP_W-1:0] rep_cnt,
    input  logic             pat_valid,
    output logic             pat_ready,
    output logic             serial_out,
    output logic             bit_valid,
    output logic             frame_end,
    output logic             busy
);

    localparam logic [3:0] BIT_LD = 4'(PAT_W - 1);
    localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_e           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [PAT_W-1:0] saved_q, saved_d;
    logic             pat_ready_q, pat_ready_d;
    logic             bit_valid_q, bit_valid_d;
    logic             frame_end_q, frame_end_d;
    logic             busy_q, busy_d;
    logic             sr_load, sr_shift;
    logic [PAT_W-1:0] sr_din;
    logic             frame_done;

    // Shifting in zeros leaves the register clear after a frame, so its MSB
    // doubles as the registered serial_out (0 in gap and idle).
    seq_shift_reg #(
        .PAT_W (PAT_W)
    ) u_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (sr_load),
        .shift   (sr_shift),
        .din     (sr_din),
        .msb     (serial_out)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        rep_d      = rep_q;
        saved_d    = saved_q;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_din     = saved_q;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pat_valid && pat_ready_q) begin
                    saved_d   = pat_in;
                    rep_d     = rep_cnt;
                    bit_cnt_d = BIT_LD;
                    sr_load   = 1'b1;
                    sr_din    = pat_in;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    sr_shift  = 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    state_d = S_PAR;
                    sr_load = 1'b1;
                    sr_din  = {^saved_q, {(PAT_W-1){1'b0}}};
`else
                    frame_done = 1'b1;
`endif
                end
            end
            S_PAR: begin
                frame_done = 1'b1;
            end
            S_GAP: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end else begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = BIT_LD;
                    sr_load   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_done) begin
            if (rep_q != '0) begin
                rep_d = rep_q - 1'b1;
                if (GAP > 0) begin
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_LD;
                    sr_shift  = 1'b1;
                end else begin
                    state_d   = S_SHIFT;
                    bit_cnt_d = BIT_LD;
                    sr_load   = 1'b1;
                    sr_din    = saved_q;
                end
            end else begin
                state_d  = S_IDLE;
                sr_shift = 1'b1;
            end
        end
    end

    // Output flags are registered from the next state so they line up with serial_out.
    always_comb begin
        pat_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        bit_valid_d = (state_d == S_SHIFT) || (state_d == S_PAR);
`ifdef SEQ_TX_PARITY_EN
        frame_end_d = (state_d == S_PAR);
`else
        frame_end_d = (state_d == S_SHIFT) && (bit_cnt_d == '0);
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            rep_q       <= '0;
            saved_q     <= '0;
            pat_ready_q <= 1'b1;
            bit_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rep_q       <= rep_d;
            saved_q     <= saved_d;
            pat_ready_q <= pat_ready_d;
            bit_valid_q <= bit_valid_d;
            frame_end_q <= frame_end_d;
            busy_q      <= busy_d;
        end
    end

    assign pat_ready = pat_ready_q;
    assign bit_valid = bit_valid_q;
    assign frame_end = frame_end_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance with GAP=2, one with GAP=0.
module tb_seq_pattern_tx;

`ifdef SEQ_TX_PARITY_EN
    localparam int L = 6;
    localparam logic [5:0] FR_A = 6'b101101;
    localparam logic [5:0] FR_B = 6'b011011;
    localparam logic [5:0] FR_C = 6'b110011;
    localparam int ONES_MAX = 32;
`else
    localparam int L = 5;
    localparam logic [4:0] FR_A = 5'b10110;
    localparam logic [4:0] FR_B = 5'b01101;
    localparam logic [4:0] FR_C = 5'b11001;
    localparam int ONES_MAX = 16;
`endif

    logic       clk;
    logic       reset_n;
    logic [4:0] pat_in;
    logic [3:0] rep_cnt;
    logic       pv, pv0;
    logic       pat_ready, serial_out, bit_valid, frame_end, busy;
    logic       pat_ready0, serial_out0, bit_valid0, frame_end0, busy0;

    int total = 0;
    int bad   = 0;

    seq_pattern_tx #(.PAT_W(5), .GAP(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pat_in     (pat_in),
        .rep_cnt    (rep_cnt),
        .pat_valid  (pv),
        .pat_ready  (pat_ready),
        .serial_out (serial_out),
        .bit_valid  (bit_valid),
        .frame_end  (frame_end),
        .busy       (busy)
    );

    seq_pattern_tx #(.PAT_W(5), .GAP(0)) dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .pat_in     (pat_in),
        .rep_cnt    (rep_cnt),
        .pat_valid  (pv0),
        .pat_ready  (pat_ready0),
        .serial_out (serial_out0),
        .bit_valid  (bit_valid0),
        .frame_end  (frame_end0),
        .busy       (busy0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Offers a word, waits (bounded) for pat_ready, returns just after the handshake edge.
    task automatic send(input logic [4:0] p, input logic [3:0] r, input bit sel0);
        int n;
        @(negedge clk);
        pat_in  = p;
        rep_cnt = r;
        if (sel0) pv0 = 1'b1; else pv = 1'b1;
        n = 0;
        while (!(sel0 ? pat_ready0 : pat_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL handshake_timeout got=no_ready exp=ready");
        end
        @(posedge clk);
        #1;
        pv  = 1'b0;
        pv0 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        pv = 1'b0; pv0 = 1'b0; pat_in = '0; rep_cnt = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({serial_out, bit_valid, frame_end, busy, pat_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=00001",
                     {serial_out, bit_valid, frame_end, busy, pat_ready});
        end
        total++;
        if ({serial_out0, bit_valid0, frame_end0, busy0, pat_ready0} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_outputs0 got=%b exp=00001",
                     {serial_out0, bit_valid0, frame_end0, busy0, pat_ready0});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [31:0] ev;
        ev = 32'(FR_A);
        send(5'b10110, 4'd0, 1'b0);
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            total++;
            if ({serial_out, bit_valid, frame_end, pat_ready} !== {ev[L-1-i], 1'b1, (i == L-1), 1'b0}) begin
                bad++;
                $display("FAIL single_bit cyc=%0d got=%b exp=%b", i + 1,
                         {serial_out, bit_valid, frame_end, pat_ready},
                         {ev[L-1-i], 1'b1, (i == L-1), 1'b0});
            end
        end
        @(negedge clk);
        total++;
        if ({serial_out, bit_valid, frame_end, busy, pat_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL single_after got=%b exp=00001",
                     {serial_out, bit_valid, frame_end, busy, pat_ready});
        end
    endtask

    task automatic test_repeat_gap();
        logic [31:0] ev, vv, fv;
        int n;
        n  = 2 * L + 2;
        ev = 32'({FR_A, 2'b00, FR_A});
        vv = 32'({{L{1'b1}}, 2'b00, {L{1'b1}}});
        fv = 32'({{(L-1){1'b0}}, 1'b1, 2'b00, {(L-1){1'b0}}, 1'b1});
        send(5'b10110, 4'd1, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if ({serial_out, bit_valid, frame_end, busy} !== {ev[n-1-i], vv[n-1-i], fv[n-1-i], 1'b1}) begin
                bad++;
                $display("FAIL gap_stream cyc=%0d got=%b exp=%b", i + 1,
                         {serial_out, bit_valid, frame_end, busy},
                         {ev[n-1-i], vv[n-1-i], fv[n-1-i], 1'b1});
            end
        end
        @(negedge clk);
        total++;
        if (pat_ready !== 1'b1) begin
            bad++;
            $display("FAIL gap_ready got=%b exp=1", pat_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ev;
        int n;
        n  = 3 * L;
        ev = 32'({FR_C, FR_C, FR_C});
        send(5'b11001, 4'd2, 1'b1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            total++;
            if ({serial_out0, bit_valid0, frame_end0, busy0} !== {ev[n-1-i], 1'b1, ((i % L) == L-1), 1'b1}) begin
                bad++;
                $display("FAIL b2b_stream cyc=%0d got=%b exp=%b", i + 1,
                         {serial_out0, bit_valid0, frame_end0, busy0},
                         {ev[n-1-i], 1'b1, ((i % L) == L-1), 1'b1});
            end
        end
        @(negedge clk);
        total++;
        if ({bit_valid0, pat_ready0} !== 2'b01) begin
            bad++;
            $display("FAIL b2b_after got=%b exp=01", {bit_valid0, pat_ready0});
        end
    endtask

    task automatic test_busy();
        logic [31:0] ea, eb;
        ea = 32'(FR_A);
        eb = 32'(FR_B);
        send(5'b10110, 4'd0, 1'b0);
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            total++;
            if ({serial_out, pat_ready} !== {ea[L-1-i], 1'b0}) begin
                bad++;
                $display("FAIL busy_first cyc=%0d got=%b exp=%b", i + 1,
                         {serial_out, pat_ready}, {ea[L-1-i], 1'b0});
            end
            if (i == 0) begin
                pat_in  = 5'b01101;
                rep_cnt = 4'd0;
                pv      = 1'b1;
            end
        end
        @(negedge clk);
        total++;
        if ({bit_valid, pat_ready} !== 2'b01) begin
            bad++;
            $display("FAIL busy_gapcycle got=%b exp=01", {bit_valid, pat_ready});
        end
        @(posedge clk);
        #1;
        pv = 1'b0;
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            total++;
            if ({serial_out, bit_valid} !== {eb[L-1-i], 1'b1}) begin
                bad++;
                $display("FAIL busy_second cyc=%0d got=%b exp=%b", i + 1,
                         {serial_out, bit_valid}, {eb[L-1-i], 1'b1});
            end
        end
        @(negedge clk);
        total++;
        if (pat_ready !== 1'b1) begin
            bad++;
            $display("FAIL busy_ready got=%b exp=1", pat_ready);
        end
    endtask

    task automatic test_max_rep();
        int c, nv, nf, n1;
        c = 0; nv = 0; nf = 0; n1 = 0;
        send(5'b10000, 4'd15, 1'b1);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (pat_ready0) break;
            c++;
            if (bit_valid0) nv++;
            if (frame_end0) nf++;
            if (serial_out0) n1++;
        end
        total++;
        if (c !== 16 * L) begin
            bad++;
            $display("FAIL maxrep_cycles got=%0d exp=%0d", c, 16 * L);
        end
        total++;
        if (nf !== 16) begin
            bad++;
            $display("FAIL maxrep_frames got=%0d exp=16", nf);
        end
        total++;
        if (nv !== 16 * L || n1 !== ONES_MAX) begin
            bad++;
            $display("FAIL maxrep_bits got=%0d/%0d exp=%0d/%0d", nv, n1, 16 * L, ONES_MAX);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] eb;
        eb = 32'(FR_B);
        send(5'b10110, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        total++;
        if ({serial_out, busy} !== 2'b11) begin
            bad++;
            $display("FAIL rstmid_bit3 got=%b exp=11", {serial_out, busy});
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({serial_out, bit_valid, frame_end, busy, pat_ready} !== 5'b00001) begin
            bad++;
            $display("FAIL rstmid_async got=%b exp=00001",
                     {serial_out, bit_valid, frame_end, busy, pat_ready});
        end
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if ({serial_out, bit_valid, busy, pat_ready} !== 4'b0001) begin
            bad++;
            $display("FAIL rstmid_release got=%b exp=0001",
                     {serial_out, bit_valid, busy, pat_ready});
        end
        send(5'b01101, 4'd0, 1'b0);
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            total++;
            if ({serial_out, bit_valid, frame_end} !== {eb[L-1-i], 1'b1, (i == L-1)}) begin
                bad++;
                $display("FAIL rstmid_next cyc=%0d got=%b exp=%b", i + 1,
                         {serial_out, bit_valid, frame_end}, {eb[L-1-i], 1'b1, (i == L-1)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_repeat_gap();
        test_back_to_back();
        test_busy();
        test_max_rep();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
